// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: job sequencer for an N x N systolic PE array (weight load, switch, skewed stream, drain).
// Optional performance counters are compiled in with PERF_CNT_EN.
module pe_array_sequencer #(
   parameter int N     = 2,
   parameter int CNT_W = 8,
   parameter int DW    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_vecs,
   output logic              busy,
   output logic              done,
   input  logic              w_valid_in,
   output logic              w_ready_out,
   input  logic [DW*N-1:0]   w_data_in,
   input  logic              x_valid_in,
   output logic              x_ready_out,
   input  logic [DW*N-1:0]   x_data_in,
   output logic [N-1:0]      accept_w_out,
   output logic [DW*N-1:0]   weight_out,
   output logic [N-1:0]      switch_out,
   output logic [N-1:0]      valid_out,
   output logic [DW*N-1:0]   input_out
`ifdef PERF_CNT_EN
   ,
   output logic [15:0]       stall_cycles,
   output logic [15:0]       job_cycles
`endif
);
   localparam int RW  = $clog2(N + 1);
   localparam int DCW = $clog2(2 * N + 1);
   typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE} state_t;
   state_t state, nxt;
   logic [CNT_W-1:0] nv, vec_cnt;
   logic [RW-1:0] row_cnt;
   logic [DCW-1:0] drain_cnt;
   logic inj_v, inj_s, w_hs, x_hs;
   logic [DW*N-1:0] inj_d;
   assign busy        = state != IDLE;
   assign done        = state == DONE;
   assign w_ready_out = state == LOAD_W;
   assign x_ready_out = state == STREAM;
   assign w_hs        = w_valid_in && w_ready_out;
   assign x_hs        = x_valid_in && x_ready_out;
   always_comb begin
      nxt   = state;
      inj_v = 1'b0;
      inj_s = 1'b0;
      inj_d = '0;
      case (state)
         IDLE:    nxt = start ? LOAD_W : IDLE;
         LOAD_W:  nxt = (w_hs && row_cnt == RW'(N - 1)) ? SWITCH : LOAD_W;
         SWITCH: begin
            inj_s = 1'b1;
            nxt   = (nv != '0) ? STREAM : DONE;
         end
         STREAM: begin
            inj_v = x_valid_in;
            inj_d = x_valid_in ? x_data_in : '0;
            nxt   = (x_hs && vec_cnt == nv - CNT_W'(1)) ? DRAIN : STREAM;
         end
         DRAIN:   nxt = (drain_cnt == DCW'(2 * N - 1)) ? DONE : DRAIN;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         nv           <= '0;
         vec_cnt      <= '0;
         row_cnt      <= '0;
         drain_cnt    <= '0;
         accept_w_out <= '0;
         weight_out   <= '0;
      end else begin
         state        <= nxt;
         accept_w_out <= w_hs ? '1 : '0;
         if (w_hs) weight_out <= w_data_in;
         if (state == IDLE && start) begin
            nv        <= num_vecs;
            vec_cnt   <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
         end
         if (w_hs) row_cnt <= row_cnt + RW'(1);
         if (x_hs) vec_cnt <= vec_cnt + CNT_W'(1);
         if (state == DRAIN) drain_cnt <= drain_cnt + DCW'(1);
      end
   end
   // row r sees the injected token r cycles after row 0
   for (genvar r = 0; r < N; r++) begin : g_row
      logic [DW+1:0] sr [0:r];
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int k = 0; k <= r; k++) sr[k] <= '0;
         end else begin
            sr[0] <= {inj_s, inj_v, inj_d[r*DW +: DW]};
            for (int k = 1; k <= r; k++) sr[k] <= sr[k-1];
         end
      end
      assign {switch_out[r], valid_out[r], input_out[r*DW +: DW]} = sr[r];
   end
`ifdef PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
         job_cycles   <= '0;
      end else if (state == IDLE && start) begin
         stall_cycles <= '0;
         job_cycles   <= '0;
      end else begin
         if (state != IDLE && job_cycles != 16'hFFFF) job_cycles <= job_cycles + 16'd1;
         if (((state == STREAM && !x_valid_in) || (state == LOAD_W && !w_valid_in)) && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb_pe_array_sequencer: directed self-checking bench for pe_array_sequencer (N = 2).
module tb_pe_array_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic [7:0] num_vecs = '0;
   logic busy, done, w_ready_out, x_ready_out;
   logic w_valid_in = 1'b0;
   logic x_valid_in = 1'b0;
   logic [31:0] w_data_in = '0;
   logic [31:0] x_data_in = '0;
   logic [1:0] accept_w_out, switch_out, valid_out;
   logic [31:0] weight_out, input_out;
`ifdef PERF_CNT_EN
   logic [15:0] stall_cycles, job_cycles;
`endif
   int total = 0;
   int bad = 0;
   int cyc, busy_n, acc_n, last_acc, sw0, sw1, v0_n, v1_n, first_v0, last_v0;
   int done_n, done_cyc, data_bad, skew_bad, busy_bad, base_len;
   logic pv0, ps0, pdone;
   logic [15:0] wq [2];
   logic [15:0] xl0, xl1;
   always #5 clk = ~clk;
   pe_array_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs), .busy(busy), .done(done),
      .w_valid_in(w_valid_in), .w_ready_out(w_ready_out), .w_data_in(w_data_in),
      .x_valid_in(x_valid_in), .x_ready_out(x_ready_out), .x_data_in(x_data_in),
      .accept_w_out(accept_w_out), .weight_out(weight_out), .switch_out(switch_out),
      .valid_out(valid_out), .input_out(input_out)
`ifdef PERF_CNT_EN
      , .stall_cycles(stall_cycles), .job_cycles(job_cycles)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic clear_stats();
      {busy_n, acc_n, last_acc, sw0, sw1, v0_n, v1_n, first_v0, last_v0} = '0;
      {done_n, done_cyc, data_bad, skew_bad, busy_bad} = '0;
      {pv0, ps0, pdone} = '0;
      wq[0] = '0;
      wq[1] = '0;
   endtask
   task automatic sample();
      cyc++;
      if (busy) busy_n++;
      if (accept_w_out == 2'b11) begin
         if (acc_n < 2) wq[acc_n] = weight_out[15:0];
         acc_n++;
         last_acc = cyc;
      end else if (accept_w_out != 2'b00) data_bad++;
      if (switch_out[0]) sw0 = cyc;
      if (switch_out[1]) sw1 = cyc;
      if (valid_out[0]) begin
         if (v0_n == 0) first_v0 = cyc;
         last_v0 = cyc;
         v0_n++;
         if (input_out[15:0] != xl0) data_bad++;
      end else if (input_out[15:0] != 16'h0) data_bad++;
      if (valid_out[1]) begin
         v1_n++;
         if (input_out[31:16] != xl1) data_bad++;
      end else if (input_out[31:16] != 16'h0) data_bad++;
      if (valid_out[1] != pv0 || switch_out[1] != ps0) skew_bad++;
      pv0 = valid_out[0];
      ps0 = switch_out[0];
      if (done) begin
         done_n++;
         done_cyc = cyc;
         if (!busy) busy_bad++;
      end
      if (pdone && busy) busy_bad++;
      pdone = done;
   endtask
   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask
   task automatic run_job(input int nv, input int wgap, input int xgap, input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] x0, input logic [15:0] x1, input bit poke);
      int wi, xi, gap;
      bit hs, got;
      logic [15:0] wr [2];
      wr[0] = w0;
      wr[1] = w1;
      xl0 = x0;
      xl1 = x1;
      clear_stats();
      start = 1'b1;
      num_vecs = 8'(nv);
      tick();
      start = 1'b0;
      wi = 0;
      gap = 0;
      for (int c = 0; c < 100 && wi < 2; c++) begin
         w_valid_in = !(wi == 1 && gap < wgap);
         w_data_in = w_valid_in ? {wr[wi], wr[wi]} : 32'hDEADBEEF;
         start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         hs = w_valid_in && w_ready_out;
         if (!w_valid_in) gap++;
         tick();
         if (hs) wi++;
      end
      w_valid_in = 1'b0;
      xi = 0;
      gap = 0;
      for (int c = 0; c < 200 && xi < nv; c++) begin
         x_valid_in = !(xi == 1 && gap < xgap);
         x_data_in = x_valid_in ? {x1, x0} : 32'hDEADBEEF;
         start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         hs = x_valid_in && x_ready_out;
         if (!x_valid_in) gap++;
         sample();
         @(posedge clk);
         #1;
         if (hs) xi++;
      end
      x_valid_in = 1'b0;
      x_data_in = 32'hDEADBEEF;
      got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
         start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         got = done_n > 0;
      end
      start = 1'b0;
      if (!got) chk("done_timeout", 0, 1);
      tick();
      tick();
   endtask
   initial begin
      cyc = 0;
      clear_stats();
      xl0 = 0;
      xl1 = 0;
      for (int i = 0; i < 4; i++) begin
         start = 1'($urandom_range(0, 1));
         w_valid_in = 1'($urandom_range(0, 1));
         x_valid_in = 1'($urandom_range(0, 1));
         w_data_in = $urandom;
         x_data_in = $urandom;
         num_vecs = 8'($urandom);
         tick();
      end
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pe", {accept_w_out, switch_out, valid_out, weight_out, input_out}, 0);
      start = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("idle_busy", busy, 0);
      chk("idle_pe", {accept_w_out, switch_out, valid_out, weight_out, input_out, done}, 0);
      // basic job
      run_job(2, 0, 0, 16'h4500, 16'h0A00, 16'h0200, 16'h0200, 0);
      chk("b_acc", acc_n, 2);
      chk("b_w0", wq[0], 16'h4500);
      chk("b_w1", wq[1], 16'h0A00);
      chk("b_sw0", sw0, last_acc + 1);
      chk("b_sw1", sw1, sw0 + 1);
      chk("b_v0", v0_n, 2);
      chk("b_v1", v1_n, 2);
      chk("b_first", first_v0, sw0 + 1);
      chk("b_last", last_v0, first_v0 + 1);
      chk("b_done_n", done_n, 1);
      chk("b_done_at", done_cyc, last_v0 + 4);
      chk("b_skew", skew_bad, 0);
      chk("b_data", data_bad, 0);
      chk("b_busy", busy_bad, 0);
      base_len = busy_n;
      chk("b_len", busy_n, 10);
      // stalls on both handshakes
      run_job(2, 3, 2, 16'h1234, 16'h8765, 16'h0100, 16'h0180, 0);
      chk("s_acc", acc_n, 2);
      chk("s_w0", wq[0], 16'h1234);
      chk("s_w1", wq[1], 16'h8765);
      chk("s_v0", v0_n, 2);
      chk("s_v1", v1_n, 2);
      chk("s_bubble", last_v0, first_v0 + 3);
      chk("s_skew", skew_bad, 0);
      chk("s_data", data_bad, 0);
      chk("s_done_n", done_n, 1);
      chk("s_done_at", done_cyc, last_v0 + 4);
      chk("s_len", busy_n, base_len + 5);
`ifdef PERF_CNT_EN
      chk("p_stall", stall_cycles, 5);
      chk("p_job", job_cycles, busy_n);
`endif
      // empty job
      run_job(0, 0, 0, 16'h0001, 16'h0002, 16'h0, 16'h0, 0);
      chk("z_acc", acc_n, 2);
      chk("z_v0", v0_n, 0);
      chk("z_v1", v1_n, 0);
      chk("z_done_at", done_cyc, last_acc + 1);
      chk("z_done_n", done_n, 1);
      chk("z_sw0", sw0, last_acc + 1);
      // start pokes while busy
      run_job(2, 0, 0, 16'h4500, 16'h0A00, 16'h0200, 16'h0200, 1);
      chk("k_len", busy_n, base_len);
      chk("k_done_n", done_n, 1);
      chk("k_v0", v0_n, 2);
      chk("k_idle", busy, 0);
      // reset in the middle of STREAM
      clear_stats();
      start = 1'b1;
      num_vecs = 8'd5;
      tick();
      start = 1'b0;
      w_valid_in = 1'b1;
      w_data_in = 32'h11112222;
      for (int c = 0; c < 20 && !x_ready_out; c++) tick();
      w_valid_in = 1'b0;
      chk("r_in_stream", x_ready_out, 1);
      x_valid_in = 1'b1;
      x_data_in = 32'h00030003;
      xl0 = 16'h0003;
      xl1 = 16'h0003;
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("r_busy", busy, 0);
      chk("r_pe", {accept_w_out, switch_out, valid_out, weight_out, input_out, done}, 0);
      x_valid_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("r_no_done", done_n, 0);
      run_job(2, 0, 0, 16'h4500, 16'h0A00, 16'h0200, 16'h0200, 0);
      chk("r2_len", busy_n, base_len);
      chk("r2_done_n", done_n, 1);
      chk("r2_v0", v0_n, 2);
      chk("r2_skew", skew_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
